operand_fetch: RTL and testbench
================================

OPERAND_FETCH -- requirements
Module: operand_fetch

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rst  input  1  reset, asynchronous, active-high.
REQ-003 in_valid  input  1  upstream request holds valid rs1_addr/rs2_addr/funct3.
REQ-004 in_ready  output  1  block can accept a request this cycle.
REQ-005 rs1_addr  input  5  first source register index.
REQ-006 rs2_addr  input  5  second source register index.
REQ-007 funct3  input  3  operation code forwarded to ALU select.
REQ-008 we  input  1  writeback enable.
REQ-009 waddr  input  5  writeback register index.
REQ-010 wdata  input  32  writeback data.
REQ-011 rs1  output  32  registered operand A to ALU.
REQ-012 rs2  output  32  registered operand B to ALU.
REQ-013 sel  output  3  registered ALU operation select.
REQ-014 out_valid  output  1  rs1/rs2/sel hold a valid operation.
REQ-015 out_ready  input  1  ALU stage consumes the operation this cycle.

Function
REQ-016 Register file SHALL hold 32 x 32-bit registers; x0 SHALL always read 0; writes to x0 SHALL be ignored.
REQ-017 Write SHALL occur at the rising edge when we=1 and waddr!=0.
REQ-018 in_ready SHALL equal (!out_valid || out_ready), combinationally.
REQ-019 Capture: at a rising edge with in_valid && in_ready, rs1/rs2 SHALL load the register file values at rs1_addr/rs2_addr, sel SHALL load funct3, out_valid SHALL become 1; latency exactly 1 cycle.
REQ-020 Drain: at a rising edge with out_valid && out_ready && !(in_valid && in_ready), out_valid SHALL become 0; rs1/rs2/sel keep their last values.
REQ-021 Simultaneous drain and capture SHALL keep out_valid=1 and load the new operation (full throughput, one op per cycle).
REQ-022 Stall: while out_valid && !out_ready, rs1/rs2/sel SHALL remain stable, except per REQ-023.
REQ-023 Stall refresh: while held, a write with we=1, waddr!=0 matching the held rs1 (rs2) index SHALL update held rs1 (rs2) with wdata at the same edge; both update if both match.
REQ-024 The block SHALL store the captured rs1/rs2 indices internally for REQ-023.
REQ-025 in_valid with in_ready=0 SHALL cause no state change; upstream holds its request.

Reset
REQ-026 rst=1 SHALL immediately clear out_valid, rs1, rs2, sel and the stored indices to 0, independent of clk.
REQ-027 rst=1 SHALL clear all 32 registers to 0.
REQ-028 Assertion mid-stall SHALL discard the held operation; no capture or write occurs while rst=1.
REQ-029 First capture SHALL be possible at the first rising edge after rst deasserts.

Configuration
REQ-030 Macro OPERAND_FETCH_BYPASS_EN: when defined, a capture coinciding with a write (we=1, waddr!=0, waddr==rs1_addr or rs2_addr) SHALL load wdata into the matching operand(s).
REQ-031 When undefined, that capture SHALL load the pre-write register value; the write still completes.

Verification
REQ-032 Write x5=226, x6=7; request rs1_addr=5, rs2_addr=6, funct3=0 -> next cycle rs1=226, rs2=7, sel=0, out_valid=1.
REQ-033 Write x0=0xFFFFFFFF; request rs1_addr=0, rs2_addr=0 -> rs1=0, rs2=0.
REQ-034 x3=10; capture rs1_addr=3 while we=1, waddr=3, wdata=99 -> rs1=99 with BYPASS_EN, rs1=10 without.
REQ-035 Hold out_ready=0 with x5 captured as rs1; write x5=55 -> rs1=55 next cycle, in_ready=0, sel unchanged.
REQ-036 Back-to-back requests funct3=1..7 with out_ready=1 -> sel=1..7 on consecutive cycles, out_valid continuously 1.
REQ-037 Assert rst during stall between clock edges -> out_valid=0 and rs1=rs2=sel=0 immediately; x5 reads 0 after release.

Source files
------------

// File: rtl/operand_fetch.sv
// operand_fetch: 32x32 register file feeding a one-entry registered operand stage toward the ALU.
// Optional feature macro OPERAND_FETCH_BYPASS_EN forwards a coincident writeback into captured operands.
module operand_fetch (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [4:0]  rs1_addr,
    input  logic [4:0]  rs2_addr,
    input  logic [2:0]  funct3,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata,
    output logic [31:0] rs1,
    output logic [31:0] rs2,
    output logic [2:0]  sel,
    output logic        out_valid,
    input  logic        out_ready
);

    // Handshake: a transfer occurs at a rising edge where valid && ready on the same side;
    // in_ready = !out_valid || out_ready, so a drain and a capture may share one edge.
    logic [31:0] r_regs [32];
    logic [31:0] r_rs1;
    logic [31:0] r_rs2;
    logic [2:0]  r_sel;
    logic        r_out_valid;
    logic [4:0]  r_rs1_idx;
    logic [4:0]  r_rs2_idx;

    logic        w_capture;
    logic        w_write;
    logic        w_held;
    logic [31:0] w_op1;
    logic [31:0] w_op2;

    assign in_ready  = !r_out_valid || out_ready;
    assign w_capture = in_valid && in_ready;
    assign w_write   = we && (waddr != 5'd0);
    assign w_held    = r_out_valid && !out_ready;

    always_comb begin
        w_op1 = r_regs[rs1_addr];
        w_op2 = r_regs[rs2_addr];
`ifdef OPERAND_FETCH_BYPASS_EN
        if (w_write && (waddr == rs1_addr)) w_op1 = wdata;
        if (w_write && (waddr == rs2_addr)) w_op2 = wdata;
`endif
    end

    // x0 is cleared at reset and never written, so it always reads zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) r_regs[i] <= 32'd0;
        end else if (w_write) begin
            r_regs[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rs1       <= 32'd0;
            r_rs2       <= 32'd0;
            r_sel       <= 3'd0;
            r_out_valid <= 1'b0;
            r_rs1_idx   <= 5'd0;
            r_rs2_idx   <= 5'd0;
        end else if (w_capture) begin
            r_rs1       <= w_op1;
            r_rs2       <= w_op2;
            r_sel       <= funct3;
            r_out_valid <= 1'b1;
            r_rs1_idx   <= rs1_addr;
            r_rs2_idx   <= rs2_addr;
        end else begin
            if (r_out_valid && out_ready) r_out_valid <= 1'b0;
            // A stalled operation must not go stale when its source register is rewritten.
            if (w_held && w_write && (waddr == r_rs1_idx)) r_rs1 <= wdata;
            if (w_held && w_write && (waddr == r_rs2_idx)) r_rs2 <= wdata;
        end
    end

    assign rs1       = r_rs1;
    assign rs2       = r_rs2;
    assign sel       = r_sel;
    assign out_valid = r_out_valid;

endmodule

// File: tb/tb_operand_fetch.sv
// Self-checking bench for operand_fetch: reference register file plus an expected-operation queue.
// Honours OPERAND_FETCH_BYPASS_EN the same way the design does.
module tb_operand_fetch;

    localparam int W = 77;  // {rs1_idx[5], rs2_idx[5], rs1[32], rs2[32], sel[3]}

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [2:0]  funct3;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [2:0]  sel;
    logic        out_valid;
    logic        out_ready;

    operand_fetch dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .rs1_addr  (rs1_addr),
        .rs2_addr  (rs2_addr),
        .funct3    (funct3),
        .we        (we),
        .waddr     (waddr),
        .wdata     (wdata),
        .rs1       (rs1),
        .rs2       (rs2),
        .sel       (sel),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [W-1:0] exp_q[$];
    logic [31:0]  m_regs [32];
    logic [W-1:0] m_last;
    int           n_checks;
    int           n_errors;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        m_last = '0;
    endtask

    // One clock cycle: drive at negedge, compare outputs, then advance the model at posedge.
    task automatic step(input logic iv, input logic [4:0] a1, input logic [4:0] a2,
                        input logic [2:0] f3, input logic w, input logic [4:0] wa,
                        input logic [31:0] wd, input logic ordy);
        logic         m_valid;
        logic         cap;
        logic [W-1:0] head;
        logic [31:0]  v1;
        logic [31:0]  v2;
        @(negedge clk);
        in_valid = iv; rs1_addr = a1; rs2_addr = a2; funct3 = f3;
        we = w; waddr = wa; wdata = wd; out_ready = ordy;
        #1;
        m_valid = (exp_q.size() > 0);
        head = m_valid ? exp_q[0] : m_last;
        check("out_valid", 32'(out_valid), 32'(m_valid));
        check("in_ready", 32'(in_ready), 32'(!m_valid || ordy));
        check("rs1", rs1, head[66:35]);
        check("rs2", rs2, head[34:3]);
        check("sel", 32'(sel), 32'(head[2:0]));
        @(posedge clk);
        cap = iv && (!m_valid || ordy);
        v1 = m_regs[a1];
        v2 = m_regs[a2];
`ifdef OPERAND_FETCH_BYPASS_EN
        if (w && wa != 5'd0 && wa == a1) v1 = wd;
        if (w && wa != 5'd0 && wa == a2) v2 = wd;
`endif
        if (m_valid && ordy) begin
            m_last = exp_q.pop_front();
        end else if (m_valid) begin
            if (w && wa != 5'd0 && wa == head[76:72]) head[66:35] = wd;
            if (w && wa != 5'd0 && wa == head[71:67]) head[34:3] = wd;
            exp_q[0] = head;
        end
        if (cap) exp_q.push_back({a1, a2, v1, v2, f3});
        if (w && wa != 5'd0) m_regs[wa] = wd;
    endtask

    task automatic write_reg(input logic [4:0] wa, input logic [31:0] wd);
        step(1'b0, 5'd0, 5'd0, 3'd0, 1'b1, wa, wd, 1'b1);
    endtask

    task automatic idle(input logic ordy);
        step(1'b0, 5'd0, 5'd0, 3'd0, 1'b0, 5'd0, 32'd0, ordy);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        model_reset();
        rst = 1'b1; in_valid = 1'b0; rs1_addr = '0; rs2_addr = '0; funct3 = '0;
        we = 1'b0; waddr = '0; wdata = '0; out_ready = 1'b0;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_rs1", rs1, 32'd0);
        check("rst_sel", 32'(sel), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Basic reads, x0 behaviour and the capture/write coincidence.
        write_reg(5'd5, 32'd226);
        write_reg(5'd6, 32'd7);
        write_reg(5'd3, 32'd10);
        write_reg(5'd0, 32'hFFFF_FFFF);
        step(1'b1, 5'd5, 5'd6, 3'd0, 1'b0, 5'd0, 32'd0, 1'b1);
        step(1'b1, 5'd0, 5'd0, 3'd2, 1'b0, 5'd0, 32'd0, 1'b1);
        step(1'b1, 5'd3, 5'd6, 3'd4, 1'b1, 5'd3, 32'd99, 1'b1);
        idle(1'b1);
        idle(1'b1);

        // Stall with refresh of the held operands; blocked requests must not disturb state.
        step(1'b1, 5'd5, 5'd6, 3'd5, 1'b0, 5'd0, 32'd0, 1'b1);
        step(1'b1, 5'd1, 5'd2, 3'd6, 1'b1, 5'd5, 32'd55, 1'b0);
        step(1'b1, 5'd1, 5'd2, 3'd6, 1'b1, 5'd6, 32'd66, 1'b0);
        step(1'b1, 5'd1, 5'd2, 3'd6, 1'b1, 5'd9, 32'd77, 1'b0);
        step(1'b0, 5'd0, 5'd0, 3'd0, 1'b0, 5'd0, 32'd0, 1'b0);
        idle(1'b1);
        idle(1'b1);

        // Full-throughput stream of funct3 = 1..7.
        for (int f = 1; f <= 7; f++)
            step(1'b1, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 3'(f),
                 1'b0, 5'd0, 32'd0, 1'b1);
        idle(1'b1);

        // Random traffic over a small register window to hit matches often.
        for (int n = 0; n < 300; n++)
            step(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
                 $urandom, 1'($urandom_range(0, 3) != 0));
        idle(1'b1);
        idle(1'b1);

        // Asynchronous reset in the middle of a stall.
        write_reg(5'd5, 32'h1234_5678);
        step(1'b1, 5'd5, 5'd5, 3'd3, 1'b0, 5'd0, 32'd0, 1'b1);
        idle(1'b0);
        #3;
        rst = 1'b1;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_rs1", rs1, 32'd0);
        check("midrst_rs2", rs2, 32'd0);
        check("midrst_sel", 32'(sel), 32'd0);
        model_reset();
        rst = 1'b0;
        step(1'b1, 5'd5, 5'd0, 3'd1, 1'b0, 5'd0, 32'd0, 1'b1);
        idle(1'b1);
        idle(1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
